iq_agc_mdl: RTL and testbench
=============================

// Module: iq_agc_mdl
// PURPOSE
// Closed-loop receive AGC. Directly downstream of the PA nonlinear-distortion model.
// Scales the distorted 16-bit I/Q stream so mean |I|+|Q| sits at TARGET before the MSK demod.
// Block-averaged power detector, fast ACQ / slow TRACK loop gain, freeze input, lock flag.
// PARAMETERS
// AVG_LOG2     6      samples per averaging block = 2**AVG_LOG2
// TARGET       8192   target block mean of |I|+|Q| on output (unsigned, 17b)
// GAIN_INIT    4096   gain after reset, unsigned Q4.12 (4096 = 1.0)
// GAIN_MIN     256    lower gain clamp (Q4.12)
// GAIN_MAX     65535  upper gain clamp (Q4.12)
// MU_ACQ       2      loop right-shift in ACQ
// MU_TRK       6      loop right-shift in TRACK
// LOCK_THR     256    |err| below this counts toward lock
// UNLOCK_THR   2048   |err| above this in TRACK forces ACQ
// LOCK_CNT     4      consecutive in-threshold blocks needed for lock
// PORTS
// clk        in   1   system clock
// reset_n    in   1   synchronous active-low reset
// in_valid   in   1   i_in/q_in valid this cycle
// i_in       in   16  signed in-phase from distortion stage
// q_in       in   16  signed quadrature from distortion stage
// freeze     in   1   hold gain and loop state while high
// out_valid  out  1   i_out/q_out valid
// i_out      out  16  signed scaled in-phase
// q_out      out  16  signed scaled quadrature
// gain       out  16  current gain, Q4.12
// locked     out  1   loop in TRACK
// BEHAVIOUR
// - One clock. Reset is synchronous and active-low.
// - Reset (reset_n==0 at posedge, including mid-block):
//   - i_out=q_out=0, out_valid=0, gain=GAIN_INIT, locked=0, state=ACQ.
//   - Accumulator, sample counter and lock counter cleared; pipeline valids flushed.
// - Datapath is 2-stage, latency 2 cycles from in_valid to out_valid, no stalls, one sample per cycle max.
//   - S1 registers the 32b signed product in*gain; gain is zero-extended to 17b signed.
//   - S2 computes (p + 2048) >>> 12 and saturates to [-32768, 32767].
// - Gain sampled by S1 is the register value that cycle.
//   - A gain update at edge N applies to samples entering S1 at edge N+1 or later.
// - Detector works on S2 output; it accumulates only when out_valid=1.
//   - mag = |i_out| + |q_out|, 17b unsigned; |-32768| = 32768.
//   - acc width 17+AVG_LOG2.
//   - Sample counter is AVG_LOG2 bits and wraps at 2**AVG_LOG2.
// - Block end: last valid sample of the block. At that edge, acc and counter clear; the next sample starts a new block.
//   - avg = (acc+mag) >> AVG_LOG2.
//   - err = TARGET - avg, 18b signed.
// - Gain update (block end only, freeze=0):
//   - g = gain + (err >>> MU), where MU = MU_ACQ or MU_TRK by state.
//   - Computed in 20b signed, then clamped to [GAIN_MIN, GAIN_MAX].
// - State machine (evaluated at block end, freeze=0):
//   - ACQ: |err|<LOCK_THR increments lockcnt, else lockcnt=0. lockcnt reaching LOCK_CNT -> TRACK, lockcnt=0.
//   - TRACK: |err|>UNLOCK_THR -> ACQ, lockcnt=0; otherwise stay.
//   - locked = (state==TRACK), registered.
// - freeze=1: gain, state, locked and lockcnt are held.
//   - Detector keeps accumulating and block boundaries still occur; the block result is discarded.
//   - Freeze asserted on the block-end edge suppresses that update.
// - Gaps in in_valid pause counting only; partial blocks persist across gaps.
// TESTING
// 1. reset_n=0 mid-block with gain=9000 -> next cycle: outputs 0, out_valid 0, gain 4096, locked 0; new block starts from 0.
// 2. i=q=4096 continuous, GAIN_INIT -> i_out=q_out=4096 at latency 2, err=0, gain stays 4096, locked=1 after block 4 end.
// 3. i=q=1024 continuous -> gain rises in ACQ, settles to 16384+/-16, i_out~4096, locked=1; then step input to 2048 -> TRACK->ACQ, relock near 8192.
// 4. gain=16384, i=32767, q=-32768 -> i_out=32767, q_out=-32768 (saturated, no wrap).
// 5. in=0 continuous -> gain climbs, clamps at 65535, never exceeds, locked=0; then i=q=30000 -> gain clamps down to GAIN_MIN=256 floor only if err demands.
// 6. Locked at gain 16384, freeze=1, input steps 1024->4096 for 10 blocks -> gain stays 16384, locked stays 1; freeze=0 -> update on the next block end.

Source files
------------

// File: rtl/iq_agc_mdl.sv
// Closed-loop receive AGC: 2-stage I/Q scaler with a block-averaged |I|+|Q| detector,
// ACQ/TRACK loop gain, freeze input and lock flag.
module iq_agc_mdl #(
  parameter int AVG_LOG2   = 6,
  parameter int TARGET     = 8192,
  parameter int GAIN_INIT  = 4096,
  parameter int GAIN_MIN   = 256,
  parameter int GAIN_MAX   = 65535,
  parameter int MU_ACQ     = 2,
  parameter int MU_TRK     = 6,
  parameter int LOCK_THR   = 256,
  parameter int UNLOCK_THR = 2048,
  parameter int LOCK_CNT   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  input  logic               freeze,
  output logic               out_valid,
  output logic signed [15:0] i_out,
  output logic signed [15:0] q_out,
  output logic        [15:0] gain,
  output logic               locked
);

  localparam int ACC_W = 17 + AVG_LOG2;
  localparam int LCK_W = $clog2(LOCK_CNT + 1);

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  function automatic logic signed [15:0] rnd_sat(input logic signed [31:0] p);
    logic signed [32:0] r;
    r = ($signed({p[31], p}) + 33'sd2048) >>> 12;
    if (r > 33'sd32767)       return 16'sh7fff;
    else if (r < -33'sd32768) return 16'sh8000;
    else                      return r[15:0];
  endfunction

  function automatic logic [16:0] abs16(input logic signed [15:0] x);
    logic signed [16:0] e;
    e = {x[15], x};
    return e[16] ? unsigned'(-e) : unsigned'(e);
  endfunction

  function automatic logic [15:0] clamp_gain(input logic signed [19:0] g);
    if (g < $signed(20'(GAIN_MIN)))      return 16'(GAIN_MIN);
    else if (g > $signed(20'(GAIN_MAX))) return 16'(GAIN_MAX);
    else                                 return g[15:0];
  endfunction

  logic signed [31:0] prod_i_p1_q, prod_i_p1_d, prod_q_p1_q, prod_q_p1_d;
  logic               vld_p1_q, vld_p1_d;
  logic signed [15:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [LCK_W-1:0]   lockcnt_q, lockcnt_d;
  state_t             state_q, state_d;
  logic [15:0]        gain_q, gain_d;
  logic               locked_q, locked_d;

  logic signed [16:0] gain_s;
  logic [16:0]        mag;
  logic [ACC_W-1:0]   acc_sum;
  logic [16:0]        avg;
  logic signed [17:0] err, err_sh;
  logic [17:0]        abs_err;
  logic               blk_end;
  logic signed [19:0] g_new;

  always_comb begin
    // S1: product with the gain register as it stands this cycle
    gain_s      = $signed({1'b0, gain_q});
    vld_p1_d    = in_valid;
    prod_i_p1_d = in_valid ? 32'(i_in) * 32'(gain_s) : prod_i_p1_q;
    prod_q_p1_d = in_valid ? 32'(q_in) * 32'(gain_s) : prod_q_p1_q;

    // S2: round, saturate
    out_valid_d = vld_p1_q;
    i_out_d     = vld_p1_q ? rnd_sat(prod_i_p1_q) : i_out_q;
    q_out_d     = vld_p1_q ? rnd_sat(prod_q_p1_q) : q_out_q;
  end

  always_comb begin
    mag     = abs16(i_out_q) + abs16(q_out_q);
    acc_sum = acc_q + ACC_W'(mag);
    blk_end = out_valid_q && (cnt_q == '1);
    avg     = 17'(acc_sum >> AVG_LOG2);
    err     = $signed(18'(TARGET)) - $signed({1'b0, avg});
    abs_err = err[17] ? unsigned'(-err) : unsigned'(err);
    err_sh  = (state_q == TRACK) ? (err >>> MU_TRK) : (err >>> MU_ACQ);
    g_new   = $signed({4'b0000, gain_q}) + 20'(err_sh);

    acc_d     = acc_q;
    cnt_d     = cnt_q;
    gain_d    = gain_q;
    state_d   = state_q;
    lockcnt_d = lockcnt_q;

    if (out_valid_q) begin
      acc_d = blk_end ? '0 : acc_sum;
      cnt_d = cnt_q + 1'b1;
    end

    // Block result is dropped while frozen; boundaries still advance above
    if (blk_end && !freeze) begin
      gain_d = clamp_gain(g_new);
      if (state_q == ACQ) begin
        if (abs_err < 18'(LOCK_THR)) begin
          if (lockcnt_q + 1'b1 == LCK_W'(LOCK_CNT)) begin
            state_d   = TRACK;
            lockcnt_d = '0;
          end else begin
            lockcnt_d = lockcnt_q + 1'b1;
          end
        end else begin
          lockcnt_d = '0;
        end
      end else if (abs_err > 18'(UNLOCK_THR)) begin
        state_d   = ACQ;
        lockcnt_d = '0;
      end
    end

    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk) begin
    prod_i_p1_q <= prod_i_p1_d;
    prod_q_p1_q <= prod_q_p1_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      lockcnt_q   <= '0;
      state_q     <= ACQ;
      gain_q      <= 16'(GAIN_INIT);
      locked_q    <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      lockcnt_q   <= lockcnt_d;
      state_q     <= state_d;
      gain_q      <= gain_d;
      locked_q    <= locked_d;
    end
  end

  assign out_valid = out_valid_q;
  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign gain      = gain_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_iq_agc_mdl.sv
// Randomized bench for iq_agc_mdl against a sample-level behavioural model of the AGC loop.
module tb_iq_agc_mdl;

  localparam int BLK    = 64;
  localparam int TARGET = 8192;
  localparam int G_INIT = 4096;
  localparam int G_MIN  = 256;
  localparam int G_MAX  = 65535;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic signed [15:0] i_in, q_in;
  logic               freeze;
  logic               out_valid;
  logic signed [15:0] i_out, q_out;
  logic        [15:0] gain;
  logic               locked;

  int checks = 0;
  int errors = 0;

  iq_agc_mdl dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
    .freeze(freeze), .out_valid(out_valid), .i_out(i_out), .q_out(q_out),
    .gain(gain), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model state
  int     m_gain, m_lockcnt, m_cnt;
  bit     m_trk;
  longint m_acc;
  bit     s1_v, o_v;
  int     s1_i, s1_q, o_i, o_q;
  bit     seen_floor;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int scale(input int x, input int g);
    longint p;
    p = (longint'(x) * g + 2048) >>> 12;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_edge(input bit rst, input bit v, input int i, input int q, input bit frz);
    bit be;
    int err, g, aerr;
    if (rst) begin
      m_gain = G_INIT; m_trk = 0; m_lockcnt = 0; m_cnt = 0; m_acc = 0;
      s1_v = 0; o_v = 0; o_i = 0; o_q = 0;
      return;
    end
    be = 0;
    err = 0;
    if (o_v) begin
      m_acc += iabs(o_i) + iabs(o_q);
      m_cnt++;
      if (m_cnt == BLK) begin
        be = 1;
        err = TARGET - int'(m_acc / BLK);
        m_acc = 0;
        m_cnt = 0;
      end
    end
    if (s1_v) begin o_i = s1_i; o_q = s1_q; end
    o_v = s1_v;
    s1_v = v;
    if (v) begin s1_i = scale(i, m_gain); s1_q = scale(q, m_gain); end
    if (be && !frz) begin
      g = m_gain + (err >>> (m_trk ? 6 : 2));
      m_gain = (g < G_MIN) ? G_MIN : (g > G_MAX) ? G_MAX : g;
      aerr = iabs(err);
      if (!m_trk) begin
        if (aerr < 256) begin
          m_lockcnt++;
          if (m_lockcnt == 4) begin m_trk = 1; m_lockcnt = 0; end
        end else m_lockcnt = 0;
      end else if (aerr > 2048) begin
        m_trk = 0; m_lockcnt = 0;
      end
    end
  endtask

  task automatic cyc(input bit v, input int i, input int q, input bit frz, input bit rstn);
    @(negedge clk);
    in_valid = v; i_in = 16'(i); q_in = 16'(q); freeze = frz; reset_n = rstn;
    @(posedge clk);
    model_edge(!rstn, v, i, q, frz);
    #1;
    chk("out_valid", out_valid, o_v);
    if (o_v) begin
      chk("i_out", i_out, o_i);
      chk("q_out", q_out, o_q);
    end
    chk("gain", gain, m_gain);
    chk("locked", locked, m_trk);
    if (gain == 16'(G_MIN)) seen_floor = 1;
  endtask

  function automatic int rsign(input int m);
    return ($urandom_range(1) != 0) ? m : -m;
  endfunction

  int g_hold;

  initial begin
    reset_n = 0; in_valid = 0; i_in = 0; q_in = 0; freeze = 0;
    seen_floor = 0;
    model_edge(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("rst_i", i_out, 0);
    chk("rst_q", q_out, 0);
    chk("rst_gain", gain, G_INIT);

    // Unity gain at target level
    repeat (BLK * 5 + 4) cyc(1, 4096, 4096, 0, 1);
    chk("unity_lock", locked, 1);
    chk("unity_gain", gain, G_INIT);

    // Low-level input with gaps: gain rises to ~16384, then level step forces reacquire
    repeat (BLK * 60) cyc($urandom_range(7) != 0, rsign(1024), rsign(1024), 0, 1);
    chk("acq_lock", locked, 1);
    chk("acq_gain_near", (iabs(int'(gain) - 16384) <= 600), 1);
    repeat (BLK * 40) cyc($urandom_range(7) != 0, rsign(2048), rsign(2048), 0, 1);
    chk("step_lock", locked, 1);
    chk("step_gain_near", (iabs(int'(gain) - 8192) <= 600), 1);

    // Reset mid-block with gain far from init
    repeat (10) cyc(1, 1000, -1000, 0, 1);
    cyc(1, 1000, -1000, 0, 0);
    chk("mid_rst_gain", gain, G_INIT);
    chk("mid_rst_i", i_out, 0);
    chk("mid_rst_vld", out_valid, 0);

    // Zero input: gain climbs to ceiling, then full-scale input drives it to the floor
    repeat (BLK * 40) cyc(1, 0, 0, 0, 1);
    chk("ceil_gain", gain, G_MAX);
    chk("ceil_unlocked", locked, 0);
    repeat (3) cyc(1, 32767, -32768, 0, 1);
    chk("sat_hi", i_out, 32767);
    chk("sat_lo", q_out, -32768);
    repeat (BLK * 20) cyc(1, 32767, -32768, 0, 1);
    chk("floor_hit", seen_floor, 1);

    // Lock near 16384, saturation probe, then freeze across a level step
    cyc(1, 0, 0, 0, 0);
    repeat (BLK * 50) cyc(1, 1024, 1024, 0, 1);
    chk("frz_pre_lock", locked, 1);
    cyc(1, 32767, -32768, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("sat16k_i", i_out, 32767);
    chk("sat16k_q", q_out, -32768);
    g_hold = int'(gain);
    repeat (BLK * 10) cyc(1, 4096, 4096, 1, 1);
    chk("frz_gain", gain, g_hold);
    chk("frz_lock", locked, 1);
    repeat (BLK * 3) cyc(1, 4096, 4096, 0, 1);
    chk("unfrz_moved", (int'(gain) < g_hold), 1);

    // Fully random traffic with freeze pulses and rare resets
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(3) != 0, int'($urandom_range(65535)) - 32768,
          int'($urandom_range(65535)) - 32768, $urandom_range(15) == 0,
          $urandom_range(499) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
